audio_chan_engine: RTL



---
 rtl/audio_chan_engine.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/audio_chan_engine.sv
// Multi-channel audio engine: per-channel first-order IIR (bypass/LPF/HPF/mute) feeding a FWFT output FIFO.
// Four cycles from acceptance to FIFO write; a full FIFO stalls the FSM in PUSH and samples arriving meanwhile are dropped.
module audio_chan_engine #(
  parameter  int N        = 10,
  parameter  int CHANNELS = 2,
  parameter  int COEF_W   = 16,
  parameter  int DEPTH    = 4,
  localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int LW       = $clog2(DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [CW-1:0]              in_ch,
  input  logic [N-1:0]               in_data,
  output logic                       in_ready,
  input  logic [2*CHANNELS-1:0]      mode,
  input  logic [COEF_W*CHANNELS-1:0] alpha,
  output logic                       out_valid,
  output logic [N-1:0]               out_data,
  output logic [CW-1:0]              out_ch,
  input  logic                       out_ready,
  output logic [LW-1:0]              fifo_level,
  output logic [7:0]                 drop_count
);

  localparam int W  = N + COEF_W;
  localparam int PW = $clog2(DEPTH);
  localparam logic [N-1:0] MID   = N'(1) << (N - 1);
  localparam logic [W-1:0] Y_RST = {MID, {COEF_W{1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, MUL, ACC, PUSH} state_t;
  state_t state, state_nxt;

  logic [N-1:0]      x_r;
  logic [CW-1:0]     ch_r;
  logic [1:0]        mode_r;
  logic [COEF_W-1:0] alpha_r;
  logic signed [W:0]   d_r;
  logic signed [W+1:0] p_r;
  logic [N-1:0]      res_r;
  logic [W-1:0]      y_reg [CHANNELS];

  logic [N-1:0]  mem_dat [DEPTH];
  logic [CW-1:0] mem_ch  [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  logic ch_ok, accept, pop, push_ok;
  assign ch_ok     = 32'(in_ch) < CHANNELS;
  assign in_ready  = (state == IDLE);
  assign accept    = in_valid & in_ready & ch_ok;
  assign out_valid = (fifo_level != '0);
  assign pop       = out_valid & out_ready;
  assign push_ok   = (state == PUSH) & ((fifo_level < LW'(DEPTH)) | pop);
  assign out_data  = mem_dat[rd_ptr];
  assign out_ch    = mem_ch[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOAD;
      LOAD:    state_nxt = MUL;
      MUL:     state_nxt = ACC;
      ACC:     state_nxt = PUSH;
      PUSH:    if (push_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Filter arithmetic; operands are sign/zero extended to the product width so nothing wraps.
  logic [W-1:0]               y_cur;
  logic signed [W+COEF_W+1:0] d_ext, a_ext, prod;
  logic signed [W+1:0]        ysum;
  logic [W-1:0]               ynew;
  logic [N-1:0]               lpf;
  logic signed [N+1:0]        hsum;
  logic [N-1:0]               hpf;
  logic                       unused_prod_bits;

  assign y_cur = y_reg[ch_r];
  assign d_ext = {{(COEF_W+1){d_r[W]}}, d_r};
  assign a_ext = {{(W+2){1'b0}}, alpha_r};
  assign prod  = d_ext * a_ext;
  assign unused_prod_bits = ^prod[COEF_W-1:0];
  assign ysum  = $signed({2'b00, y_cur}) + p_r;
  assign lpf   = ynew[W-1:COEF_W];
  assign hsum  = $signed({2'b00, x_r}) - $signed({2'b00, lpf}) + $signed({2'b00, MID});

  always_comb begin
    ynew = ysum[W-1:0];
    if (ysum[W+1])  ynew = '0;
    else if (ysum[W]) ynew = '1;
    hpf = hsum[N-1:0];
    if (hsum[N+1])  hpf = '0;
    else if (hsum[N]) hpf = '1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_r     <= '0;
      ch_r    <= '0;
      mode_r  <= '0;
      alpha_r <= '0;
      d_r     <= '0;
      p_r     <= '0;
      res_r   <= '0;
      for (int i = 0; i < CHANNELS; i++) y_reg[i] <= Y_RST;
    end else begin
      if (accept) begin
        x_r     <= in_data;
        ch_r    <= in_ch;
        mode_r  <= mode[int'(in_ch)*2 +: 2];
        alpha_r <= alpha[int'(in_ch)*COEF_W +: COEF_W];
      end
      if (state == LOAD) d_r <= $signed({1'b0, x_r, {COEF_W{1'b0}}}) - $signed({1'b0, y_cur});
      if (state == MUL)  p_r <= prod[W+COEF_W+1:COEF_W];
      if (state == ACC) begin
        y_reg[ch_r] <= ynew;
        case (mode_r)
          2'b00:   res_r <= x_r;
          2'b01:   res_r <= lpf;
          2'b10:   res_r <= hpf;
          default: res_r <= MID;
        endcase
      end
    end
  end

  // A full FIFO still accepts the stalled push on a pop cycle; the freed slot is the one being written.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      drop_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_dat[i] <= '0;
        mem_ch[i]  <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_dat[wr_ptr] <= res_r;
        mem_ch[wr_ptr]  <= ch_r;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (in_valid && (!in_ready || !ch_ok) && drop_count != 8'hFF)
        drop_count <= drop_count + 1'b1;
    end
  end

endmodule
